// File: rtl/cpu_ctrl_fsm.sv
// Control unit for the accumulator datapath: fetch / decode / execute
// sequencing, multiplier handshake with timeout, halt and error status.
module cpu_ctrl_fsm #(
  parameter int MULT_MAX_WAIT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opcode,
  input  logic             zflag,
  input  logic             mult_done,
  output logic             muxPC,
  output logic             muxMAR,
  output logic             muxACC,
  output logic             muxOUT,
  output logic             loadMAR,
  output logic             loadPC,
  output logic             loadACC,
  output logic             loadMDR,
  output logic             loadIR,
  output logic [1:0]       opALU,
  output logic             mult_ld,
  output logic             mem_we,
  output logic             halted,
  output logic             mult_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_JZ    = 8'h07;
  localparam logic [7:0] OP_MULT  = 8'h08;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  // Wait counter must hold values up to MULT_MAX_WAIT-1.
  localparam int          WW        = $clog2(MULT_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MULT_MAX_WAIT - 1);

  // Four-bit encoding leaves spare codes; those fall back to F1.
  typedef enum logic [3:0] {
    F1    = 4'd0,
    F2    = 4'd1,
    F3    = 4'd2,
    DEC   = 4'd3,
    E1    = 4'd4,
    E2    = 4'd5,
    MWAIT = 4'd6,
    HALT  = 4'd7
  } state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt;
  logic            inc_cnt, clr_wait, inc_wait, set_err;

  // State, retired-instruction count, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= F1;
      instr_count <= '0;
      mult_err    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_n;
      if (inc_cnt)  instr_count <= instr_count + CNT_W'(1);
      if (set_err)  mult_err    <= 1'b1;
      if (clr_wait)      wait_cnt <= '0;
      else if (inc_wait) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Next state and control outputs; everything is forced low during reset.
  always_comb begin
    state_n  = state;
    muxPC    = 1'b0;
    muxMAR   = 1'b0;
    muxACC   = 1'b0;
    muxOUT   = 1'b0;
    loadMAR  = 1'b0;
    loadPC   = 1'b0;
    loadACC  = 1'b0;
    loadMDR  = 1'b0;
    loadIR   = 1'b0;
    opALU    = 2'b00;
    mult_ld  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    inc_cnt  = 1'b0;
    clr_wait = 1'b0;
    inc_wait = 1'b0;
    set_err  = 1'b0;
    case (state)
      F1: begin
        loadMAR = 1'b1;
        state_n = F2;
      end
      F2: begin
        loadMDR = 1'b1;
        state_n = F3;
      end
      F3: begin
        loadIR  = 1'b1;
        loadPC  = 1'b1;
        inc_cnt = 1'b1;
        state_n = DEC;
      end
      DEC: begin
        state_n = F1;
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_MULT: begin
            loadMAR = 1'b1;
            muxMAR  = 1'b1;
            state_n = E1;
          end
          OP_JMP: begin
            loadPC = 1'b1;
            muxPC  = 1'b1;
          end
          OP_JZ: begin
            loadPC = zflag;
            muxPC  = zflag;
          end
          OP_HALT: state_n = HALT;
          default: state_n = F1;
        endcase
      end
      E1: begin
        if (opcode == OP_STORE) begin
          mem_we  = 1'b1;
          state_n = F1;
        end else begin
          loadMDR = 1'b1;
          state_n = E2;
        end
      end
      E2: begin
        state_n = F1;
        case (opcode)
          OP_LOAD: begin
            loadACC = 1'b1;
            muxACC  = 1'b1;
          end
          OP_ADD: loadACC = 1'b1;
          OP_SUB: begin
            loadACC = 1'b1;
            opALU   = 2'b01;
          end
          OP_AND: begin
            loadACC = 1'b1;
            opALU   = 2'b10;
          end
          OP_MULT: begin
            mult_ld  = 1'b1;
            clr_wait = 1'b1;
            state_n  = MWAIT;
          end
          default: state_n = F1;
        endcase
      end
      MWAIT: begin
        if (mult_done) begin
          loadACC = 1'b1;
          muxOUT  = 1'b1;
          state_n = F1;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err = 1'b1;
          state_n = HALT;
        end else begin
          inc_wait = 1'b1;
        end
      end
      HALT: halted = 1'b1;
      default: state_n = F1;
    endcase
    if (rst) begin
      muxPC   = 1'b0;
      muxMAR  = 1'b0;
      muxACC  = 1'b0;
      muxOUT  = 1'b0;
      loadMAR = 1'b0;
      loadPC  = 1'b0;
      loadACC = 1'b0;
      loadMDR = 1'b0;
      loadIR  = 1'b0;
      opALU   = 2'b00;
      mult_ld = 1'b0;
      mem_we  = 1'b0;
      halted  = 1'b0;
    end
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Control unit that sequences the 8-bit-address / 16-bit-data accumulator datapath through fetch, decode and execute.
- Drives every datapath mux, load and ALU select, plus the memory write strobe.
- Handshakes with the datapath's pipelined 8x8 multiplier (mult_ld / mult_done) and enforces a wait timeout.
- Exposes halt/error status and a retired-instruction counter for the bench.

Parameters:
- MULT_MAX_WAIT, 16, max cycles in MWAIT before declaring a multiplier timeout (>=1)
- CNT_W, 16, width of instr_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  8  IR[7:0] from datapath
- zflag  in  1  ACC==0 from datapath
- mult_done  in  1  multiplier result valid
- muxPC  out  1  0: PC+1, 1: IR[15:8]
- muxMAR  out  1  0: PC, 1: IR[15:8]
- muxACC  out  1  0: ALU/mult path, 1: MDR
- muxOUT  out  1  1: multiplier result onto ACC ALU-side input
- loadMAR, loadPC, loadACC, loadMDR, loadIR  out  1 each  register load enables
- opALU  out  2  00 ADD, 01 SUB, 10 AND, 11 pass-ACC
- mult_ld  out  1  one-cycle multiplier start pulse
- mem_we  out  1  memory write strobe (MemD=ACC at MemAddr=MAR)
- halted  out  1  in HALT state
- mult_err  out  1  sticky multiplier timeout flag
- instr_count  out  CNT_W  instructions fetched since reset

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset:
  - State goes to F1; instr_count=0; mult_err=0; wait counter=0.
  - While rst=1, all control outputs are forced to 0, and halted=0.
- Memory read is combinational from MAR: data is loaded into MDR in the cycle after MAR is loaded.
- Instruction encoding: opcode=IR[7:0], operand address=IR[15:8].
  - 01 LOAD, 02 STORE, 03 ADD, 04 SUB, 05 AND, 06 JMP, 07 JZ, 08 MULT, FF HALT.
  - All other opcodes are NOP.
- Control outputs are 0 in every state unless listed below.
- State sequence:
  - F1: loadMAR=1, muxMAR=0 -> F2
  - F2: loadMDR=1 -> F3
  - F3: loadIR=1, loadPC=1, muxPC=0; instr_count+=1 (wraps at 2^CNT_W) -> DEC
  - DEC, dispatching on opcode:
    - LOAD/STORE/ADD/SUB/AND/MULT: loadMAR=1, muxMAR=1 -> E1
    - JMP: loadPC=1, muxPC=1 -> F1
    - JZ: if zflag=1, loadPC=1, muxPC=1; -> F1 either way
    - HALT -> HALT
    - NOP/unknown -> F1
  - E1:
    - STORE: mem_we=1 -> F1
    - Otherwise: loadMDR=1 -> E2
  - E2:
    - LOAD: loadACC=1, muxACC=1 -> F1
    - ADD/SUB/AND: loadACC=1, muxACC=0, opALU=00/01/10 -> F1
    - MULT: mult_ld=1, wait counter cleared -> MWAIT
  - MWAIT:
    - mult_done=1: loadACC=1, muxACC=0, muxOUT=1 -> F1 (Mealy on mult_done).
    - Otherwise the counter increments. When the counter reaches MULT_MAX_WAIT without mult_done: mult_err<=1, ACC untouched -> HALT.
  - HALT: halted=1; all other controls 0; stays until rst.
- Cycles per instruction:
  - JMP/JZ/NOP: 4. STORE: 5. LOAD/ALU ops: 6.
  - MULT: 7 + done latency (mult_done arriving in the first MWAIT cycle gives 7).
- mult_ld is exactly one cycle per MULT instruction.
- mult_done outside MWAIT is ignored.
- zflag is sampled only in DEC for JZ (reflects ACC before the branch).
- Reset mid-operation (any state, including MWAIT with an outstanding multiply): the next state is F1, and any later stray mult_done is ignored.
- opcode is decoded only in DEC and E1/E2; it is held stable by IR, because loadIR is asserted only in F3.
- Unused state encodings recover to F1.

Test Plan:
- Reset, then release:
  - With rst=1 for 3 cycles, every control output is 0 and instr_count=0.
  - On the first cycle after release, loadMAR=1, muxMAR=0.
- Program LOAD 0x10 (M=0x0005); ADD 0x11 (M=0x0003); STORE 0x12:
  - loadACC muxACC=1, then opALU=00 loadACC.
  - mem_we pulses once with MemAddr=0x12 while ACC=0x0008.
  - instr_count=3 after 17 cycles.
- JZ 0x40:
  - With ACC=0: loadPC, muxPC=1 in DEC, and the next fetch is from 0x40.
  - With ACC=1: no branch load in DEC, and fetch continues at PC+1.
- MULT with mult_done asserted 3 cycles after mult_ld:
  - Single mult_ld pulse.
  - loadACC+muxOUT asserted in the same cycle as mult_done.
  - Returns to F1 the following cycle.
- MULT with mult_done never asserted (MULT_MAX_WAIT=16): after 16 MWAIT cycles, mult_err=1, halted=1, and no loadACC.
- Opcode 0x3C (unknown) -> 4-cycle NOP.
- Opcode FF -> halted=1 held for 50 cycles with no loads.
- rst pulsed during MWAIT, with mult_done arriving later, produces no loadACC.
